// File: rtl/ann_layer_seq.sv
// ann_layer_seq: one fully-connected ANN layer sequenced around a single shared signed MAC,
// with shift, ReLU and saturation applied to each neuron's sum before it is written out.
module ann_layer_seq #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int DW    = 8,
    parameter int SHIFT = 0,
    parameter int ACCW  = 2*DW+$clog2(N_IN),
    localparam int XAW  = $clog2(N_IN),
    localparam int WAW  = $clog2(N_IN*N_OUT),
    localparam int YAW  = N_OUT > 1 ? $clog2(N_OUT) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           done,
    output logic           mem_re,
    output logic [XAW-1:0] x_addr,
    output logic [WAW-1:0] w_addr,
    input  logic [DW-1:0]  x_data,
    input  logic [DW-1:0]  w_data,
    output logic           y_we,
    output logic [YAW-1:0] y_addr,
    output logic [DW-1:0]  y_data
);
    typedef enum logic [2:0] {IDLE, CLEAR, RUN, LAST, WRITE, DONE} state_t;
    localparam logic [WAW-1:0] N_IN_W = WAW'(N_IN);
    localparam logic signed [ACCW-1:0] Y_MAX = ACCW'((1 << (DW-1)) - 1);
    state_t state, state_nx;
    logic [XAW-1:0] i;
    logic [YAW-1:0] j;
    logic mac_en_d, last_i, last_j;
    logic signed [ACCW-1:0] acc, s;
    logic signed [2*DW-1:0] prod;
    assign last_i = i == XAW'(N_IN-1);
    assign last_j = j == YAW'(N_OUT-1);
    assign prod = (2*DW)'($signed(x_data)) * (2*DW)'($signed(w_data));
    assign s = acc >>> SHIFT;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CLEAR : IDLE;
            CLEAR:   state_nx = RUN;
            RUN:     state_nx = last_i ? LAST : RUN;
            LAST:    state_nx = WRITE;
            WRITE:   state_nx = last_j ? DONE : CLEAR;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
        busy   = state != IDLE;
        done   = state == DONE;
        mem_re = state == RUN;
        y_we   = state == WRITE && !abort;
        x_addr = i;
        w_addr = WAW'(j) * N_IN_W + WAW'(i);
        y_addr = j;
        y_data = s[ACCW-1] ? '0 : (s > Y_MAX ? DW'(Y_MAX) : s[DW-1:0]);
    end
    // read data lags mem_re by one cycle, so the MAC enable is the delayed RUN decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            i        <= '0;
            j        <= '0;
            acc      <= '0;
            mac_en_d <= 1'b0;
        end else begin
            state    <= state_nx;
            mac_en_d <= state == RUN && !abort;
            if (state == IDLE) j <= '0;
            if (state == CLEAR) begin
                i   <= '0;
                acc <= '0;
            end else if (mac_en_d) begin
                acc <= acc + ACCW'(prod);
            end
            if (state == RUN) i <= i + XAW'(1);
            if (state == WRITE && !last_j) j <= j + YAW'(1);
        end
    end
endmodule

// File: tb/tb_ann_layer_seq.sv
// tb_ann_layer_seq: scoreboard bench for ann_layer_seq; two instances (SHIFT=0 and SHIFT=2)
// each fed by a 1-cycle-latency memory model, expected writes produced by a dot-product model.
`timescale 1ns/1ps
module tb_ann_layer_seq;
    localparam int NI = 4;
    localparam int NO = 2;
    localparam int PASS_CYC = NO*(NI+3)+1;
    typedef struct {int k; int a; int d;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start [2];
    logic abort [2];
    logic busy [2];
    logic done [2];
    logic mem_re [2];
    logic y_we [2];
    logic [1:0] x_addr [2];
    logic [2:0] w_addr [2];
    logic [7:0] xd [2];
    logic [7:0] wd [2];
    logic [0:0] y_addr [2];
    logic [7:0] y_data [2];
    logic [7:0] xm [2][4];
    logic [7:0] wm [2][8];
    exp_t exp_q [$];
    exp_t mon_e;
    int done_cnt [2];
    int n_chk = 0;
    int n_pass = 0;

    ann_layer_seq #(.N_IN(NI), .N_OUT(NO), .DW(8), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .busy(busy[0]), .done(done[0]),
        .mem_re(mem_re[0]), .x_addr(x_addr[0]), .w_addr(w_addr[0]), .x_data(xd[0]), .w_data(wd[0]),
        .y_we(y_we[0]), .y_addr(y_addr[0]), .y_data(y_data[0]));
    ann_layer_seq #(.N_IN(NI), .N_OUT(NO), .DW(8), .SHIFT(2)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .busy(busy[1]), .done(done[1]),
        .mem_re(mem_re[1]), .x_addr(x_addr[1]), .w_addr(w_addr[1]), .x_data(xd[1]), .w_data(wd[1]),
        .y_we(y_we[1]), .y_addr(y_addr[1]), .y_data(y_data[1]));

    always #5 clk = ~clk;

    always @(posedge clk)
        for (int k = 0; k < 2; k++)
            if (mem_re[k]) begin
                xd[k] <= xm[k][x_addr[k]];
                wd[k] <= wm[k][w_addr[k]];
            end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    always @(negedge clk)
        for (int k = 0; k < 2; k++) begin
            if (done[k]) done_cnt[k]++;
            if (y_we[k]) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_write: inst %0d y_addr=%0d y_data=%0d, expected no write",
                             k, y_addr[k], y_data[k]);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_inst", k, mon_e.k);
                    check("y_addr", int'(y_addr[k]), mon_e.a);
                    check("y_data", int'(y_data[k]), mon_e.d);
                end
            end
        end

    // dot product of the whole row, then shift and clamp into [0,127]
    function automatic int ref_y(input int k, input int j);
        int acc, s, a, b;
        acc = 0;
        for (int i = 0; i < NI; i++) begin
            a = int'($signed(xm[k][i]));
            b = int'($signed(wm[k][j*NI+i]));
            acc += a * b;
        end
        s = acc >>> (k == 0 ? 0 : 2);
        return s < 0 ? 0 : (s > 127 ? 127 : s);
    endfunction

    task automatic load(input int k, input int xv [4], input int wv [8]);
        for (int i = 0; i < 4; i++) xm[k][i] = 8'(xv[i]);
        for (int i = 0; i < 8; i++) wm[k][i] = 8'(wv[i]);
    endtask

    function automatic int outs(input int k);
        return int'({busy[k], done[k], mem_re[k], y_we[k], x_addr[k], w_addr[k], y_addr[k], y_data[k]});
    endfunction

    // mode 0: plain pass, 1: extra start pulse at cycle ev, 2: abort at cycle ev, 3: async reset at cycle ev
    task automatic run_pass(input int k, input int mode, input int ev);
        int c, d0;
        bit seen;
        c = 0;
        seen = 1'b0;
        d0 = done_cnt[k];
        for (int j = 0; j < NO; j++)
            if (mode < 2 || (j+1)*(NI+3) < ev) exp_q.push_back('{k, j, ref_y(k, j)});
        @(posedge clk); #1 start[k] = 1'b1;
        @(posedge clk); #1 start[k] = 1'b0;
        while (!seen && c < 100) begin
            @(negedge clk);
            c++;
            seen = done[k];
            start[k] = mode == 1 && c == ev;
            if (mode == 2 && c == ev) abort[k] = 1'b1;
            if (mode == 2 && c == ev+1) begin
                check("abort_idle_busy", int'(busy[k]), 0);
                abort[k] = 1'b0;
                break;
            end
            if (mode == 3 && c == ev) begin
                rst = 1'b1;
                #1 check("async_rst_outputs", outs(k), 0);
                @(negedge clk) rst = 1'b0;
                break;
            end
        end
        if (mode < 2) begin
            check("done_cycle", c, PASS_CYC);
            @(negedge clk);
            check("busy_after_done", int'(busy[k]), 0);
        end
        repeat (20) @(negedge clk);
        check("done_count", done_cnt[k] - d0, int'(mode < 2));
        check("writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        int xv [4];
        int wv [8];
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0;
            abort[k] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs_0", outs(0), 0);
        check("reset_outputs_1", outs(1), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        load(0, '{1, 2, 3, 4}, '{1, 1, 1, 1, -1, -1, -1, -1});
        run_pass(0, 0, 0);
        load(0, '{100, 100, 100, 100}, '{100, 100, 100, 100, 100, 100, 100, 100});
        run_pass(0, 0, 0);
        load(0, '{-128, -128, -128, -128}, '{-128, -128, -128, -128, -128, -128, -128, -128});
        run_pass(0, 0, 0);
        load(0, '{1, 2, 3, 4}, '{1, 1, 1, 1, -1, -1, -1, -1});
        run_pass(0, 1, 5);
        run_pass(0, 2, 10);
        run_pass(0, 0, 0);
        run_pass(0, 3, 6);
        run_pass(0, 0, 0);
        @(posedge clk); #1 start[0] = 1'b1; abort[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0; abort[0] = 1'b0;
        @(negedge clk) check("start_abort_idle", int'(busy[0]), 0);
        load(1, '{3, 3, 3, 3}, '{2, 2, 2, 2, -1, 0, 0, 0});
        run_pass(1, 0, 0);
        for (int r = 0; r < 6; r++)
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
                for (int i = 0; i < 8; i++) wv[i] = int'($urandom_range(0, 255)) - 128;
                load(k, xv, wv);
                run_pass(k, 0, 0);
            end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1, "timeout");
    end
endmodule
